// File: rtl/regfile_arbiter.sv
// Core/debug two-port arbiter in front of the GPIO register block, all outputs registered.
// Define REGARB_DBG_PRIORITY_EN to grant debug on every simultaneous request (default: round-robin).
module regfile_arbiter #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_rwn,
  input  logic [2:0]  c_addr,
  input  logic [3:0]  c_wben,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_rwn,
  input  logic [2:0]  d_addr,
  input  logic [3:0]  d_wben,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [2:0]  reg_addr,
  output logic        reg_rwn,
  output logic [3:0]  reg_wben,
  output logic [31:0] reg_wdata,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  localparam logic [1:0] CntLoad = 2'(RD_LATENCY - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        owner_d;
  logic        txn_rwn_q, txn_rwn_d;
  logic [2:0]  txn_addr_q, txn_addr_d;
  logic [3:0]  txn_wben_q, txn_wben_d;
  logic [31:0] txn_wdata_q, txn_wdata_d;
  logic        any_req, gnt_dbg, tie_dbg;

  logic        c_ack_d, d_ack_d, reg_rwn_d, busy_d;
  logic [31:0] c_rdata_d, d_rdata_d, reg_wdata_d;
  logic [2:0]  reg_addr_d;
  logic [3:0]  reg_wben_d;

  assign any_req = c_req | d_req;
  assign gnt_dbg = (c_req & d_req) ? tie_dbg : d_req;

`ifdef REGARB_DBG_PRIORITY_EN
  assign tie_dbg = 1'b1;
`else
  // Remembers who won the last grant; resets to debug so the core wins the first tie.
  logic last_dbg_q;
  assign tie_dbg = ~last_dbg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dbg_q <= 1'b1;
    end else if (state_q == StIdle && any_req) begin
      last_dbg_q <= gnt_dbg;
    end
  end
`endif

  // State register, latched transaction and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner       <= 1'b0;
      txn_rwn_q   <= 1'b1;
      txn_addr_q  <= '0;
      txn_wben_q  <= '0;
      txn_wdata_q <= '0;
      c_ack       <= 1'b0;
      d_ack       <= 1'b0;
      c_rdata     <= '0;
      d_rdata     <= '0;
      reg_addr    <= '0;
      reg_rwn     <= 1'b1;
      reg_wben    <= '0;
      reg_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner       <= owner_d;
      txn_rwn_q   <= txn_rwn_d;
      txn_addr_q  <= txn_addr_d;
      txn_wben_q  <= txn_wben_d;
      txn_wdata_q <= txn_wdata_d;
      c_ack       <= c_ack_d;
      d_ack       <= d_ack_d;
      c_rdata     <= c_rdata_d;
      d_rdata     <= d_rdata_d;
      reg_addr    <= reg_addr_d;
      reg_rwn     <= reg_rwn_d;
      reg_wben    <= reg_wben_d;
      reg_wdata   <= reg_wdata_d;
      busy        <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner;
    txn_rwn_d   = txn_rwn_q;
    txn_addr_d  = txn_addr_q;
    txn_wben_d  = txn_wben_q;
    txn_wdata_d = txn_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d     = StIssue;
          owner_d     = gnt_dbg;
          txn_rwn_d   = gnt_dbg ? d_rwn   : c_rwn;
          txn_addr_d  = gnt_dbg ? d_addr  : c_addr;
          txn_wben_d  = gnt_dbg ? d_wben  : c_wben;
          txn_wdata_d = gnt_dbg ? d_wdata : c_wdata;
        end
      end
      StIssue: begin
        if (txn_rwn_q) begin
          state_d = StWait;
          cnt_d   = CntLoad;
        end else begin
          state_d = StAck;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StAck;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the output registers, decoded from the upcoming state
  always_comb begin
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_rwn_d   = 1'b1;
    reg_wben_d  = 4'b0000;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    c_rdata_d   = c_rdata;
    d_rdata_d   = d_rdata;
    busy_d      = (state_d != StIdle);
    if (state_d == StIssue) begin
      reg_addr_d  = txn_addr_d;
      reg_wdata_d = txn_wdata_d;
      reg_rwn_d   = txn_rwn_d;
      reg_wben_d  = txn_rwn_d ? 4'b0000 : txn_wben_d;
    end
    if (state_d == StAck) begin
      c_ack_d = ~owner_d;
      d_ack_d = owner_d;
    end
    // Final WAIT cycle: register-block data is valid now
    if (state_q == StWait && cnt_q == 2'd0) begin
      if (owner) d_rdata_d = reg_rdata;
      else       c_rdata_d = reg_rdata;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants, latencies and register contents.
module tb_regfile_arbiter;

  localparam int unsigned LAT = 1;

  typedef struct packed {
    logic        rwn;
    logic [2:0]  addr;
    logic [3:0]  wben;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_rwn, d_req, d_rwn;
  logic [2:0]  c_addr, d_addr, reg_addr;
  logic [3:0]  c_wben, d_wben, reg_wben;
  logic [31:0] c_wdata, d_wdata, c_rdata, d_rdata, reg_wdata, reg_rdata;
  logic        c_ack, d_ack, reg_rwn, busy, owner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_rwn(c_rwn), .c_addr(c_addr), .c_wben(c_wben), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_rwn(d_rwn), .d_addr(d_addr), .d_wben(d_wben), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .reg_addr(reg_addr), .reg_rwn(reg_rwn), .reg_wben(reg_wben), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic is_ro(input logic [2:0] a);
    return (a == 3'd0) || (a == 3'd1) || (a == 3'd3);
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 0) return 32'h48524A44;
    if (a == 1) return 32'h00010002;
    if (a == 3) return 32'h000000FF;
    return 32'h11111111 * a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  // Register block stand-in: byte-enabled writes, read-only words, LAT-deep read pipe
  logic [31:0] blk_mem [8];
  logic [31:0] rd_pipe [LAT];
  assign reg_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) blk_mem[i] <= init_val(i);
    end else if (!reg_rwn && !is_ro(reg_addr)) begin
      blk_mem[reg_addr] <= merge(blk_mem[reg_addr], reg_wdata, reg_wben);
    end
    rd_pipe[0] <= blk_mem[reg_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state
  logic [31:0] exp_mem [8];
  logic        last_dbg;
  logic [31:0] c_prev, d_prev;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_mem[i] = init_val(i);
    last_dbg = 1'b1;
    c_prev   = '0;
    d_prev   = '0;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.rwn   = 1'($urandom_range(0, 1));
    t.addr  = 3'($urandom_range(0, 7));
    t.wben  = 4'($urandom);
    t.wdata = $urandom;
    return t;
  endfunction

  function automatic txn_t mk(input logic rwn, input logic [2:0] a, input logic [3:0] be,
                              input logic [31:0] d);
    txn_t t;
    t.rwn = rwn; t.addr = a; t.wben = be; t.wdata = d;
    return t;
  endfunction

  task automatic drive_c(input txn_t t);
    c_req = 1'b1; c_rwn = t.rwn; c_addr = t.addr; c_wben = t.wben; c_wdata = t.wdata;
  endtask

  task automatic drive_d(input txn_t t);
    d_req = 1'b1; d_rwn = t.rwn; d_addr = t.addr; d_wben = t.wben; d_wdata = t.wdata;
  endtask

  // Starts at an IDLE negedge; the requester with offset 0 (or the tie winner) is granted in
  // cycle 0, the other one in the first IDLE cycle at or after its own offset.
  task automatic run_txns(input logic c_en, input txn_t ct, input int c_off,
                          input logic d_en, input txn_t dt, input int d_off);
    logic w_dbg, e_c_ack, e_d_ack, c_bsy, d_bsy, e_wr;
    int   lat_c, lat_d, g_c, g_d, t_c, t_d, n, n_end;
    lat_c = ct.rwn ? LAT + 2 : 2;
    lat_d = dt.rwn ? LAT + 2 : 2;
    if (c_en && d_en && c_off == 0 && d_off == 0) begin
`ifdef REGARB_DBG_PRIORITY_EN
      w_dbg = 1'b1;
`else
      w_dbg = ~last_dbg;
`endif
    end else begin
      w_dbg = d_en && (d_off == 0);
    end
    g_c = -10; g_d = -10; t_c = -10; t_d = -10;
    if (w_dbg) begin
      g_d = 0; t_d = lat_d;
      if (c_en) begin g_c = (c_off > t_d + 1) ? c_off : t_d + 1; t_c = g_c + lat_c; end
    end else begin
      g_c = 0; t_c = lat_c;
      if (d_en) begin g_d = (d_off > t_c + 1) ? d_off : t_c + 1; t_d = g_d + lat_d; end
    end
    last_dbg = (c_en && d_en) ? ~w_dbg : w_dbg;
    n_end = (t_c > t_d) ? t_c : t_d;
    if (c_en && c_off == 0) drive_c(ct);
    if (d_en && d_off == 0) drive_d(dt);
    n = 0;
    while (n < n_end) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      e_c_ack = c_en && (n == t_c);
      e_d_ack = d_en && (n == t_d);
      c_bsy   = c_en && (n > g_c) && (n <= t_c);
      d_bsy   = d_en && (n > g_d) && (n <= t_d);
      e_wr    = (c_en && !ct.rwn && n == g_c + 1) || (d_en && !dt.rwn && n == g_d + 1);
      if (e_c_ack) begin
        if (ct.rwn) c_prev = exp_mem[ct.addr];
        else if (!is_ro(ct.addr)) exp_mem[ct.addr] = merge(exp_mem[ct.addr], ct.wdata, ct.wben);
      end
      if (e_d_ack) begin
        if (dt.rwn) d_prev = exp_mem[dt.addr];
        else if (!is_ro(dt.addr)) exp_mem[dt.addr] = merge(exp_mem[dt.addr], dt.wdata, dt.wben);
      end
      n_checks += 5;
      if (c_ack !== e_c_ack) begin
        n_errors++; $display("FAIL c_ack n=%0d got=%b exp=%b", n, c_ack, e_c_ack);
      end
      if (d_ack !== e_d_ack) begin
        n_errors++; $display("FAIL d_ack n=%0d got=%b exp=%b", n, d_ack, e_d_ack);
      end
      if (busy !== (c_bsy || d_bsy)) begin
        n_errors++; $display("FAIL busy n=%0d got=%b exp=%b", n, busy, c_bsy || d_bsy);
      end
      if (reg_rwn !== !e_wr) begin
        n_errors++; $display("FAIL reg_rwn n=%0d got=%b exp=%b", n, reg_rwn, !e_wr);
      end
      if (c_rdata !== c_prev) begin
        n_errors++; $display("FAIL c_rdata n=%0d got=%h exp=%h", n, c_rdata, c_prev);
      end
      n_checks++;
      if (d_rdata !== d_prev) begin
        n_errors++; $display("FAIL d_rdata n=%0d got=%h exp=%h", n, d_rdata, d_prev);
      end
      if (c_bsy || d_bsy) begin
        n_checks++;
        if (owner !== d_bsy) begin
          n_errors++; $display("FAIL owner n=%0d got=%b exp=%b", n, owner, d_bsy);
        end
      end
      if (!e_wr) begin
        n_checks++;
        if (reg_wben !== 4'b0000) begin
          n_errors++; $display("FAIL reg_wben_idle n=%0d got=%h exp=0", n, reg_wben);
        end
      end
      if (c_en && n == g_c + 1) begin
        n_checks++;
        if (reg_addr !== ct.addr || (!ct.rwn && (reg_wben !== ct.wben || reg_wdata !== ct.wdata)))
        begin
          n_errors++;
          $display("FAIL c_issue n=%0d got=%h/%h/%h exp=%h/%h/%h", n, reg_addr, reg_wben,
                   reg_wdata, ct.addr, ct.wben, ct.wdata);
        end
      end
      if (d_en && n == g_d + 1) begin
        n_checks++;
        if (reg_addr !== dt.addr || (!dt.rwn && (reg_wben !== dt.wben || reg_wdata !== dt.wdata)))
        begin
          n_errors++;
          $display("FAIL d_issue n=%0d got=%h/%h/%h exp=%h/%h/%h", n, reg_addr, reg_wben,
                   reg_wdata, dt.addr, dt.wben, dt.wdata);
        end
      end
      if (e_c_ack) c_req = 1'b0;
      if (e_d_ack) d_req = 1'b0;
      if (c_en && c_off == n) drive_c(ct);
      if (d_en && d_off == n) drive_d(dt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (c_ack !== 1'b0 || d_ack !== 1'b0) begin
      n_errors++; $display("FAIL rst_ack got=%b%b exp=00", c_ack, d_ack);
    end
    if (c_rdata !== '0 || d_rdata !== '0) begin
      n_errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", c_rdata, d_rdata);
    end
    if (reg_rwn !== 1'b1 || reg_wben !== 4'b0) begin
      n_errors++; $display("FAIL rst_rwn_wben got=%b/%h exp=1/0", reg_rwn, reg_wben);
    end
    if (reg_addr !== '0 || reg_wdata !== '0) begin
      n_errors++; $display("FAIL rst_addr_wdata got=%h/%h exp=0/0", reg_addr, reg_wdata);
    end
    if (busy !== 1'b0 || owner !== 1'b0) begin
      n_errors++; $display("FAIL rst_busy_owner got=%b/%b exp=0/0", busy, owner);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_core_write();
    run_txns(1'b1, mk(1'b0, 3'b110, 4'hF, 32'hDEADBEEF), 0, 1'b0, mk(1'b1, 3'd0, 4'h0, 0), 0);
  endtask

  task automatic test_core_read();
    run_txns(1'b1, mk(1'b1, 3'b000, 4'h0, 0), 0, 1'b0, mk(1'b1, 3'd0, 4'h0, 0), 0);
    run_txns(1'b1, mk(1'b1, 3'b110, 4'h0, 0), 0, 1'b0, mk(1'b1, 3'd0, 4'h0, 0), 0);
  endtask

  task automatic test_back_to_back_tie();
    for (int i = 0; i < 2; i++) run_txns(1'b1, rand_txn(), 0, 1'b1, rand_txn(), 0);
  endtask

  task automatic test_dbg_then_core();
    run_txns(1'b1, mk(1'b1, 3'b101, 4'h0, 0), 1, 1'b1, mk(1'b0, 3'b101, 4'b0001, 32'hA5), 0);
  endtask

  task automatic test_reset_in_wait();
    drive_c(mk(1'b1, 3'd2, 4'h0, 0));
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b0 || c_ack !== 1'b0 || d_ack !== 1'b0) begin
      n_errors++; $display("FAIL rstwait_state got=%b/%b/%b exp=0/0/0", busy, c_ack, d_ack);
    end
    if (reg_rwn !== 1'b1 || reg_wben !== 4'b0) begin
      n_errors++; $display("FAIL rstwait_reg got=%b/%h exp=1/0", reg_rwn, reg_wben);
    end
    if (c_rdata !== '0) begin
      n_errors++; $display("FAIL rstwait_rdata got=%h exp=0", c_rdata);
    end
    reset = 1'b0;
    c_req = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (c_ack !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL rstwait_quiet got=%b/%b exp=0/0", c_ack, busy);
      end
    end
    run_txns(1'b1, mk(1'b1, 3'd0, 4'h0, 0), 0, 1'b0, mk(1'b1, 3'd0, 4'h0, 0), 0);
    run_txns(1'b0, mk(1'b1, 3'd0, 4'h0, 0), 0, 1'b1, mk(1'b1, 3'd2, 4'h0, 0), 0);
  endtask

  task automatic test_random();
    int  mode;
    int  off;
    logic first_dbg;
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 3);
      off  = $urandom_range(1, 3);
      first_dbg = 1'($urandom_range(0, 1));
      unique case (mode)
        0: run_txns(1'b1, rand_txn(), 0, 1'b0, rand_txn(), 0);
        1: run_txns(1'b0, rand_txn(), 0, 1'b1, rand_txn(), 0);
        2: run_txns(1'b1, rand_txn(), 0, 1'b1, rand_txn(), 0);
        default: run_txns(1'b1, rand_txn(), first_dbg ? off : 0,
                          1'b1, rand_txn(), first_dbg ? 0 : off);
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    c_req = 1'b0; c_rwn = 1'b1; c_addr = '0; c_wben = '0; c_wdata = '0;
    d_req = 1'b0; d_rwn = 1'b1; d_addr = '0; d_wben = '0; d_wdata = '0;
    model_reset();
    test_reset();
    test_core_write();
    test_core_read();
    test_back_to_back_tie();
    test_dbg_then_core();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
